// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the binary-to-BCD display path: FSM states,
// the segment-decoder glyph codes and the per-digit output width.
package bcd_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [3:0] GLYPH_BLANK = 4'hA;
   localparam logic [3:0] GLYPH_P     = 4'hB;
   localparam logic [3:0] GLYPH_L     = 4'hC;
   localparam logic [3:0] GLYPH_E     = 4'hD;
   localparam logic [3:0] GLYPH_S     = 4'hE;
   localparam logic [3:0] GLYPH_F     = 4'hF;

   localparam int DIGIT_W = 8;

endpackage

// File: rtl/bin2bcd_display_if.sv
// Request/result bundle between the debug register-view path and the
// BCD display converter.
interface bin2bcd_display_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  blank_lz;
   logic                  busy;
   logic                  done;
   logic [8*DIGITS-1:0]   digits;

   modport master (
      output start, bin_in, blank_lz,
      input  busy, done, digits
   );

   modport slave (
      input  start, bin_in, blank_lz,
      output busy, done, digits
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 (4-bit wrap).
// Purely combinational, no flow control.
module bcd_digit_adj (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);
   assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;
endmodule

// File: rtl/bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with optional leading-zero
// blanking; result registered BIN_W+1 clocks after accept, start ignored while busy.
module bin2bcd_display
   import bcd_disp_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   bin2bcd_display_if.slave  bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam int OUT_W = DIGIT_W * DIGITS;

   // DIGITS >= ceil(BIN_W*log10(2)), evaluated in fixed point.
   if (DIGITS * 100000 < BIN_W * 30103) begin : g_bad_digits
      $error("bin2bcd_display: DIGITS too small for BIN_W");
   end

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               blank_q, blank_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [OUT_W-1:0]   digits_q, digits_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [OUT_W-1:0]   disp_c;
   logic               lead_c;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .dig_i (bcd_q[4*g +: 4]),
         .dig_o (bcd_adj[4*g +: 4])
      );
   end

   // Leading zeros are blanked from the top down; digit 0 always shows.
   always_comb begin
      disp_c = '0;
      lead_c = blank_q;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         disp_c[DIGIT_W*i +: DIGIT_W] = {4'h0, bcd_q[4*i +: 4]};
         if ((i != 0) && lead_c && (bcd_q[4*i +: 4] == 4'h0)) begin
            disp_c[DIGIT_W*i +: DIGIT_W] = {4'h0, GLYPH_BLANK};
         end else begin
            lead_c = 1'b0;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      blank_d  = blank_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      digits_d = digits_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               bin_d   = bus.bin_in;
               bcd_d   = '0;
               blank_d = bus.blank_lz;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            digits_d = disp_c;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         blank_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         digits_q <= {DIGITS{{4'h0, GLYPH_BLANK}}};
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         blank_q  <= blank_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         digits_q <= digits_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.digits = digits_q;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed-vector bench for bin2bcd_display; expected digit codes queued at
// issue time and popped by an independent monitor on each done pulse.
module tb_bin2bcd_display;
   localparam int BIN_W   = 16;
   localparam int DIGITS  = 5;
   localparam int LAT     = BIN_W + 1;

   typedef struct {
      logic [39:0] dig;
      int          acc;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   n_done;
   int   n_expected;
   exp_t sb[$];

   bin2bcd_display_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin2bcd_display #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(bus.digits), 64'hDEAD);
         end else begin
            e = sb.pop_front();
            check({e.name, "_digits"}, 64'(bus.digits), 64'(e.dig));
            check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(LAT));
            check({e.name, "_busy_low"}, 64'(bus.busy), 64'd0);
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (bus.busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (bus.busy) check("idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   // Drives a one-cycle start at the current negedge; optionally queues the expectation.
   task automatic issue(input logic [15:0] val, input logic blz, input logic push,
                        input logic [39:0] dig, input string name);
      bus.start    = 1'b1;
      bus.bin_in   = val;
      bus.blank_lz = blz;
      if (push) begin
         exp_t e;
         e.dig  = dig;
         e.acc  = cyc + 1;
         e.name = name;
         sb.push_back(e);
         n_expected++;
      end
      @(negedge clk);
      bus.start    = 1'b0;
      bus.bin_in   = 16'hFFFF;
      bus.blank_lz = ~blz;
   endtask

   task automatic convert(input logic [15:0] val, input logic blz,
                          input logic [39:0] dig, input string name);
      wait_idle();
      issue(val, blz, 1'b1, dig, name);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!bus.done && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; n_done = 0; n_expected = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.bin_in = '0; bus.blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_digits", 64'(bus.digits), 64'h0A0A0A0A0A);
      check("rst_busy",   64'(bus.busy),   64'd0);
      check("rst_done",   64'(bus.done),   64'd0);

      convert(16'hFFFF, 1'b0, 40'h06_05_05_03_05, "ffff");
      check("busy_during", 64'(bus.busy), 64'd1);
      check("hold_digits", 64'(bus.digits), 64'h0A0A0A0A0A);
      convert(16'd1234,  1'b1, 40'h0A_01_02_03_04, "1234_blank");
      convert(16'd1234,  1'b0, 40'h00_01_02_03_04, "1234_noblank");
      convert(16'd0,     1'b1, 40'h0A_0A_0A_0A_00, "zero_blank");
      convert(16'd40000, 1'b1, 40'h04_00_00_00_00, "40000_blank");

      // Start while busy is dropped; start in the done cycle is taken.
      convert(16'd777, 1'b0, 40'h00_00_07_07_07, "777");
      repeat (4) @(negedge clk);
      issue(16'd5, 1'b0, 1'b0, 40'h0, "ignored");
      wait_done();
      issue(16'd5, 1'b0, 1'b1, 40'h00_00_00_00_05, "b2b_5");
      check("b2b_busy", 64'(bus.busy), 64'd1);
      wait_done();
      @(negedge clk);

      // Abort 9999 part-way through shifting; no result may appear.
      wait_idle();
      issue(16'd9999, 1'b0, 1'b0, 40'h0, "aborted");
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_digits", 64'(bus.digits), 64'h0A0A0A0A0A);
      check("abort_busy",   64'(bus.busy),   64'd0);
      check("abort_done",   64'(bus.done),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      convert(16'd42, 1'b0, 40'h00_00_00_04_02, "42");
      wait_done();
      repeat (3) @(negedge clk);

      check("queue_empty", 64'(sb.size()), 64'd0);
      check("done_count",  64'(n_done),    64'(n_expected));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/bin2bcd_display.md
# bin2bcd_display

Sequential binary-to-BCD converter feeding the board's seven-segment digit decoders. It accepts an unsigned binary value on a start pulse and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It can optionally replace leading zeros with the blank glyph code, then presents one 8-bit code per digit, sized to drive a seven-segment decoder input directly. It sits between the processor's debug/register-view path and the display decoders.

## Interface

**Parameters**
- `BIN_W`, default 16: width of the binary input.
- `DIGITS`, default 5: number of output digits.
  - Must satisfy `DIGITS >= ceil(BIN_W*0.30103)`.
  - Elaboration fails otherwise.

**Ports**
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: convert request; sampled only in IDLE.
- `bin_in`, input, BIN_W: unsigned value; latched on the accepting edge.
- `blank_lz`, input, 1: leading-zero blanking enable; latched with `bin_in`.
- `busy`, output, 1: high from the accepting edge until the result edge.
- `done`, output, 1: one-cycle pulse; the new digits are valid while it is high.
- `digits`, output, 8*DIGITS: digit i occupies `[8i+7:8i]`, with digit 0 the least significant.
  - Upper nibble of each digit is always 0.
  - Lower nibble is 0-9, or 4'hA for blank.

## Operation

**States:** IDLE, SHIFT, FINISH.
- **IDLE:**
  - `start`=1 loads the shift register with `bin_in` and clears the BCD field.
  - Latches `blank_lz`, clears the bit counter, sets `busy`, and goes to SHIFT.
  - `start`=0: stay.
- **SHIFT:** each cycle performs one double-dabble step.
  - First, every 4-bit BCD digit that is >=5 gets +3.
  - Then the combined {BCD, binary} register shifts left by 1.
  - The counter increments; after BIN_W steps, go to FINISH.
- **FINISH:**
  - Compute the displayed digits from the final BCD field.
  - Register them into `digits`.
  - Pulse `done`, clear `busy`, and return to IDLE.

**Blanking rules**
- Blanking applies only when the latched `blank_lz`=1.
- Scan from digit DIGITS-1 down to digit 1; each 0 is replaced by 4'hA until the first nonzero digit is reached.
- Digit 0 is never blanked, so an input of 0 shows a single "0".

**Other rules**
- Arithmetic: the add-3 is done on 4 bits with no carry out; a correct DIGITS makes overflow impossible.
- `start` while `busy`=1 is ignored. There is no queueing and no error flag.
- `bin_in` and `blank_lz` changes after the accepting edge have no effect on the current conversion.
- `digits` holds its previous value for the whole conversion, so the display does not flicker. It changes only on the FINISH edge.

## Timing

- Reset values (`rst_n`=0, asynchronous):
  - State IDLE; `busy`=0; `done`=0.
  - Every digit = 8'h0A (blank display).
  - Internal registers 0.
- Accepting edge E0: `busy`=1 after E0.
- Shift edges E1..E_BIN_W; FINISH edge E_{BIN_W+1}.
  - After E_{BIN_W+1}: `digits` is updated, `done`=1 and `busy`=0.
  - `done` returns to 0 after E_{BIN_W+2}.
- Latency: BIN_W+1 clocks from the accepting edge to valid result. Default: 17.
- Throughput: a `start` asserted during the `done` cycle (state IDLE) is accepted. Back-to-back conversions therefore run every BIN_W+2 clocks.
- Reset mid-conversion:
  - The conversion is abandoned immediately and every output takes its reset value.
  - No `done` pulse is issued for the abandoned request.
- `done` and `busy` are never high in the same cycle.

## Structure

- Shared package `bcd_disp_pkg` holds:
  - The state enum (IDLE/SHIFT/FINISH).
  - Glyph code constants used by the segment decoders: BLANK=4'hA, P=4'hB, L=4'hC, E=4'hD, S=4'hE, F=4'hF.
  - The digit width constant 8.
- One sub-module, `bcd_digit_adj`: combinational 4-bit "if >=5 then +3" cell.
  - Instantiated DIGITS times in a generate loop.
- Blanking is computed in the top level only; no extra submodule.

## Test plan

1. Reset, then idle with no `start` → `digits`=0x0A in all five positions; `busy`=0, `done`=0.
2. `bin_in`=16'hFFFF, `blank_lz`=0 → `done` on the 17th edge after acceptance; digits[4:0]=6,5,5,3,5.
3. `bin_in`=1234, `blank_lz`=1 → digits[4:0]=A,1,2,3,4. Repeat with `blank_lz`=0 → 0,1,2,3,4.
4. `bin_in`=0, `blank_lz`=1 → A,A,A,A,0. Then `bin_in`=40000 → 4,0,0,0,0, with inner zeros not blanked.
5. Conversion of 777 in progress; pulse `start` with `bin_in`=5 at cycle 5 → ignored.
   - Result is 0,0,7,7,7 with exactly one `done`.
   - A `start` in the `done` cycle with `bin_in`=5 → accepted; result 0,0,0,0,5 after 17 more edges.
6. Start 9999, assert `rst_n`=0 at shift step 8 → all outputs take reset values immediately and no `done` occurs.
   - A fresh convert of 42 then yields 0,0,0,4,2.
